// File: rtl/countdown_pkg.sv
// countdown_pkg: shared types and constants for the countdown timer.
package countdown_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int COUNTDOWN_WIDTH = 8;

  // Reset value and terminal-count compare reference.
  localparam logic [COUNTDOWN_WIDTH-1:0] COUNT_ZERO = '0;

endpackage

// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with valid/ready load handshake,
// enable-gated decrement, abort, and a registered one-cycle expiry pulse.
// Optional feature macro: COUNTDOWN_AUTO_RELOAD_EN -- when defined, the
// terminal decrement reloads the last loaded value and the timer keeps
// running, giving a periodic expiry until aborted.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int WIDTH = COUNTDOWN_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_value,
  output logic             load_ready,
  input  logic             enable,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             expired
);

  localparam logic [WIDTH-1:0] ZERO = WIDTH'(COUNT_ZERO);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             busy_d;
  logic             expired_q, expired_d;

  // Handshake is purely a function of the current state.
  assign load_ready = (state_q == IDLE);

  assign count   = count_q;
  assign expired = expired_q;

  // State, count, reload and output registers; async reset to idle/zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      count_q   <= ZERO;
      reload_q  <= ZERO;
      busy      <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      reload_q  <= reload_d;
      busy      <= busy_d;
      expired_q <= expired_d;
    end
  end

  // Next-state, next-count and expiry pulse; abort outranks enable.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    reload_d  = reload_q;
    expired_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load_valid) begin
          if (load_value != ZERO) begin
            count_d  = load_value;
            reload_d = load_value;
            state_d  = RUN;
          end else begin
            // Zero load expires immediately without entering RUN.
            expired_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (abort) begin
          count_d = ZERO;
          state_d = IDLE;
        end else if (enable) begin
          if (count_q <= ONE) begin
            expired_d = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            count_d = reload_q;
`else
            count_d = ZERO;
            state_d = IDLE;
`endif
          end else begin
            count_d = count_q - ONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        count_d = ZERO;
      end
    endcase
    busy_d = (state_d == RUN);
  end

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed + randomized stimulus, expected outputs from a
// behavioural model pushed into a queue and checked by a separate monitor.
module tb_countdown_timer;

  localparam int W = 8;

  logic         clk;
  logic         reset_n;
  logic         load_valid;
  logic [W-1:0] load_value;
  logic         load_ready;
  logic         enable;
  logic         abort;
  logic [W-1:0] count;
  logic         busy;
  logic         expired;

  countdown_timer #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n),
    .load_valid(load_valid), .load_value(load_value), .load_ready(load_ready),
    .enable(enable), .abort(abort),
    .count(count), .busy(busy), .expired(expired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    bit bsy;
    bit exp;
    bit rdy;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int pulses = 0;

  // Behavioural model: remaining ticks, running flag, period of last load.
  int m_rem    = 0;
  bit m_run    = 0;
  int m_period = 0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // One clock of stimulus; the model predicts the outputs after the edge.
  task automatic step(input bit lv, input int val, input bit en, input bit ab);
    exp_t e;
    @(negedge clk);
    load_valid = lv;
    load_value = W'(val);
    enable     = en;
    abort      = ab;
    e.exp = 0;
    if (!m_run) begin
      if (lv) begin
        if (val != 0) begin
          m_rem = val; m_period = val; m_run = 1;
        end else begin
          e.exp = 1;
        end
      end
    end else if (ab) begin
      m_rem = 0; m_run = 0;
    end else if (en) begin
      m_rem = m_rem - 1;
      if (m_rem == 0) begin
        e.exp = 1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        m_rem = m_period;
`else
        m_run = 0;
`endif
      end
    end
    e.cnt = m_rem;
    e.bsy = m_run;
    e.rdy = !m_run;
    q.push_back(e);
    @(posedge clk);
  endtask

  // Monitor: one expected item per clock edge, sampled 1 time unit later.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("count", int'(count), e.cnt);
        chk("busy", int'(busy), int'(e.bsy));
        chk("expired", int'(expired), int'(e.exp));
        chk("load_ready", int'(load_ready), int'(e.rdy));
        if (expired) pulses++;
      end
    end
  end

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  initial begin
    int p0;
    reset_n = 1'b0; load_valid = 1'b0; load_value = '0; enable = 1'b0; abort = 1'b0;
    #12;
    chk("rst_count", int'(count), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_expired", int'(expired), 0);
    chk("rst_ready", int'(load_ready), 1);
    @(negedge clk);
    reset_n = 1'b1;

    // Load 5, enable held high: 5,4,3,2,1,0 with one pulse at 0.
    p0 = pulses;
    step(1, 5, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    #2 chk("load5_pulses", pulses - p0, 1);

    // Load 3, enable toggled 1,0,1,0,1.
    step(1, 3, 0, 0);
    step(0, 0, 1, 0); step(0, 0, 0, 0); step(0, 0, 1, 0);
    step(0, 0, 0, 0); step(0, 0, 1, 0);
    idle_cycles(1);

    // Zero load: single pulse, never busy.
    p0 = pulses;
    step(1, 0, 1, 0);
    idle_cycles(2);
    #2 chk("load0_pulses", pulses - p0, 1);

    // Load 10, abort after 4 enables.
    p0 = pulses;
    step(1, 10, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
    step(0, 0, 1, 1);
    // Abort together with enable at count 1.
    step(1, 1, 0, 0);
    step(0, 0, 1, 1);
    idle_cycles(1);
    #2 chk("abort_pulses", pulses - p0, 0);

    // Back-to-back: load accepted in the cycle right after expiry.
    step(1, 2, 0, 0);
    step(0, 0, 1, 0); step(1, 2, 1, 0);
    step(1, 1, 1, 0); step(1, 1, 1, 0);
    step(0, 0, 1, 0);

    // Load 8, async reset at count 4.
    step(1, 8, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_count", int'(count), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_expired", int'(expired), 0);
    chk("arst_ready", int'(load_ready), 1);
    m_rem = 0; m_run = 0; m_period = 0;
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    step(1, 2, 1, 0);
    step(0, 0, 1, 0); step(0, 0, 1, 0);
    idle_cycles(1);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    // Periodic mode: load 3, nine enables, three pulses, then abort.
    p0 = pulses;
    step(1, 3, 0, 0);
    for (int i = 0; i < 9; i++) step(1, 5, 1, 0);
    #2 chk("auto_pulses", pulses - p0, 3);
    step(0, 0, 1, 1);
    idle_cycles(1);
`endif

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      bit lv, en, ab;
      int v;
      lv = ($urandom_range(0, 3) == 0);
      v  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 6);
      en = ($urandom_range(0, 3) != 0);
      ab = ($urandom_range(0, 19) == 0);
      step(lv, v, en, ab);
    end
    idle_cycles(2);
    @(posedge clk);
    #3;
    chk("queue_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Loadable down-counter that pairs with the free-running up-counter: it accepts a start value over a valid/ready handshake, decrements on a tick enable, and signals expiry with a one-cycle pulse. It sits beside the up-counter in the timing path and provides timeouts and periodic events to downstream control logic.

## Interface
- WIDTH, 8, counter and load value width in bits

- clk  input  1  single clock; all state updates on rising edge
- reset_n  input  1  asynchronous, active-low reset
- load_valid  input  1  load request; load_value is valid while high
- load_value  input  WIDTH  start value for the countdown
- load_ready  output  1  timer accepts a load this cycle
- enable  input  1  decrement tick; ignored unless running
- abort  input  1  cancel a running countdown
- count  output  WIDTH  current remaining count, registered
- busy  output  1  high while in RUN
- expired  output  1  one-cycle pulse on terminal count, registered

## Operation
- States: IDLE, RUN. Reset forces IDLE.
- load_ready = (state == IDLE). It is combinational from state and reads 1 during reset.
- A load is accepted when load_valid && load_ready at a rising edge.
- IDLE, accepted load of V != 0:
  - count <= V, go to RUN.
  - The reload register captures V.
- IDLE, accepted load of V == 0:
  - count stays 0, stay in IDLE.
  - expired pulses on the next cycle.
- IDLE: enable and abort have no effect.
- RUN, abort = 1: count <= 0, go to IDLE, no expired pulse. abort has priority over enable.
- RUN, enable = 1, count > 1: count <= count - 1.
- RUN, enable = 1, count == 1: count <= 0, expired <= 1, go to IDLE.
- RUN, enable = 0: hold.
- load_valid during RUN is not accepted because load_ready = 0. The requester must hold load_valid until accepted.
- Arithmetic is unsigned WIDTH-bit. count never wraps below 0.
- busy = (state == RUN), registered with state.

## Timing
- Reset values: count = 0, busy = 0, expired = 0, state = IDLE, reload register = 0.
- Load to first decrement:
  - The load at edge N makes count = V visible after N.
  - The first enable sampled at edge N+1 decrements.
- Expiry latency: exactly V enabled cycles after the load is accepted.
  - expired goes high in the same cycle count becomes 0.
  - expired drops in the following cycle.
- Back-to-back:
  - load_ready is high in the cycle after expiry.
  - A new load is accepted at that edge, giving zero dead cycles.
- Reset asserted mid-RUN: all outputs return to reset values immediately (asynchronous). No expired pulse is generated.
- abort and terminal decrement in the same cycle: abort wins, no pulse.

## Configuration
- Macro: COUNTDOWN_AUTO_RELOAD_EN.
- Defined:
  - On the terminal decrement in RUN, count <= reload register, expired pulses, and the timer stays in RUN.
  - Periodic expiry every V enabled cycles until abort.
  - load_ready stays 0 throughout RUN.
  - A zero load still behaves as a single expiry in IDLE, so there is no zero-period loop.
- Undefined:
  - One-shot behaviour as in Operation.
  - The reload register may be optimised away.

## Structure
- Package countdown_pkg:
  - state typedef (IDLE, RUN).
  - Default width constant COUNTDOWN_WIDTH = 8.
  - Zero constant used for reset and compare.
- Single module, no sub-module. The next-state/count logic and the output registers are small enough to stay flat.

## Test plan
- Reset release, then load 5 with enable held high:
  - load_ready drops the next cycle.
  - count sequence is 5,4,3,2,1,0.
  - expired pulses once, coincident with count = 0.
  - load_ready returns high.
- Load 3, enable toggled 1,0,1,0,1: count holds on the 0 cycles, and expiry comes after the third enabled cycle.
- Load 0: no RUN entry, busy stays 0, and a single expired pulse appears one cycle after acceptance.
- Load 10, abort after 4 enables (count = 6): count goes to 0, busy goes to 0, no expired pulse. Abort and enable together at count = 1 also gives no pulse.
- Load 8, drive reset_n low at count = 4: count, busy and expired go to 0 asynchronously. After release, a load of 2 works normally.
- With COUNTDOWN_AUTO_RELOAD_EN, load 3 and hold enable for 9 cycles:
  - count runs 3,2,1,3,2,1,3,2,1.
  - expired pulses three times.
  - load_ready stays 0 until abort.
